// File: rtl/inverse_transform_unit_pkg.sv
// Shared primitive types for the geometry pipeline plus Q8.8 constants.
package inverse_transform_unit_pkg;

    // Q8.8 format constants
    localparam int unsigned Q_FRAC = 8;
    localparam logic [15:0] Q_MAX  = 16'h7FFF;
    localparam logic [15:0] Q_MIN  = 16'h8000;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } Vertex_t;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] j;
        logic [15:0] k;
    } Vector_t;

    // Column matrix: v1, v2, v3 are the three columns
    typedef struct packed {
        Vector_t v1;
        Vector_t v2;
        Vector_t v3;
    } Matrix_t;

endpackage

// File: rtl/inverse_transform_unit_mac.sv
// Signed Q8.8 multiply-accumulate with floor-shift reduction to 16 bits.
// Q8_8_SAT_EN: when defined, out-of-range results clamp and raise sat.
module q8_8_mac
    import inverse_transform_unit_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 34
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
`ifdef Q8_8_SAT_EN
    output logic        sat,
`endif
    output logic [15:0] result
);

    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] sum;

    // Product and running sum including the current term
    always_comb begin
        prod = $signed(a) * $signed(b);
        sum  = acc_q + {{(ACC_W-32){prod[31]}}, prod};
    end

    // Clear wins over accumulate so the final term of a row can flush in one cycle
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef Q8_8_SAT_EN
    logic [ACC_W-FRAC_BITS-16:0] upper;
    // Result is representable only if all bits above bit 15 of the shifted sum match the sign
    always_comb begin
        upper  = sum[ACC_W-1:FRAC_BITS+15];
        sat    = !((&upper) || !(|upper));
        result = sum[FRAC_BITS +: 16];
        if (sat) begin
            result = sum[ACC_W-1] ? Q_MIN : Q_MAX;
        end
    end
`else
    // Arithmetic shift then keep low 16 bits (wraps on overflow)
    always_comb begin
        result = sum[FRAC_BITS +: 16];
    end
`endif

endmodule

// File: rtl/inverse_transform_unit.sv
// Computes M^T * P in Q8.8 using one shared MAC over nine cycles.
// Q8_8_SAT_EN: when defined, results saturate and out_ovf reports it.
module inverse_transform_unit
    import inverse_transform_unit_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 34
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    output logic    in_ready,
    input  Vertex_t in_point,
    input  Matrix_t in_matrix,
    output logic    out_valid,
    input  logic    out_ready,
    output Vertex_t out_point,
    output logic    out_ovf
);

    typedef enum logic [1:0] {
        s_idle,
        s_calc,
        s_out
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  term_q, term_d;
    Vertex_t     pt_q;
    Matrix_t     mat_q;
    Vertex_t     out_point_q;
    logic        load;
    logic        acc_clr;
    logic        acc_en;
    logic        wr;
    Vector_t     col;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic [15:0] mac_res;

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        term_d  = term_q;
        load    = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        wr      = 1'b0;
        case (state_q)
            s_idle: begin
                if (in_valid) begin
                    load    = 1'b1;
                    acc_clr = 1'b1;
                    row_d   = 2'd0;
                    term_d  = 2'd0;
                    state_d = s_calc;
                end
            end
            s_calc: begin
                acc_en = 1'b1;
                if (term_q == 2'd2) begin
                    wr      = 1'b1;
                    acc_clr = 1'b1;
                    term_d  = 2'd0;
                    if (row_q == 2'd2) begin
                        row_d   = 2'd0;
                        state_d = s_out;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    term_d = term_q + 2'd1;
                end
            end
            s_out: begin
                if (out_ready) begin
                    state_d = s_idle;
                end
            end
            default: state_d = s_idle;
        endcase
    end

    // Operand select: row picks the matrix column (transpose), term picks the component
    always_comb begin
        case (row_q)
            2'd0:    col = mat_q.v1;
            2'd1:    col = mat_q.v2;
            default: col = mat_q.v3;
        endcase
        case (term_q)
            2'd0: begin
                mac_a = col.i;
                mac_b = pt_q.x;
            end
            2'd1: begin
                mac_a = col.j;
                mac_b = pt_q.y;
            end
            default: begin
                mac_a = col.k;
                mac_b = pt_q.z;
            end
        endcase
    end

    // State, counters, operand capture and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= s_idle;
            row_q       <= 2'd0;
            term_q      <= 2'd0;
            pt_q        <= '0;
            mat_q       <= '0;
            out_point_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            term_q  <= term_d;
            if (load) begin
                pt_q  <= in_point;
                mat_q <= in_matrix;
            end
            if (wr) begin
                case (row_q)
                    2'd0:    out_point_q.x <= mac_res;
                    2'd1:    out_point_q.y <= mac_res;
                    default: out_point_q.z <= mac_res;
                endcase
            end
        end
    end

`ifdef Q8_8_SAT_EN
    logic       mac_sat;
    logic [2:0] ovf_q;

    // Per-component saturation flags, cleared when a new point is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 3'b000;
        end else if (load) begin
            ovf_q <= 3'b000;
        end else if (wr) begin
            ovf_q[row_q] <= mac_sat;
        end
    end

    assign out_ovf = |ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    q8_8_mac #(
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .a      (mac_a),
        .b      (mac_b),
`ifdef Q8_8_SAT_EN
        .sat    (mac_sat),
`endif
        .result (mac_res)
    );

    assign in_ready  = (state_q == s_idle);
    assign out_valid = (state_q == s_out);
    assign out_point = out_point_q;

endmodule

// File: tb/tb_inverse_transform_unit.sv
// Directed self-checking bench for inverse_transform_unit.
module tb_inverse_transform_unit;
    import inverse_transform_unit_pkg::*;

    logic    clk;
    logic    rst_n;
    logic    in_valid;
    logic    in_ready;
    Vertex_t in_point;
    Matrix_t in_matrix;
    logic    out_valid;
    logic    out_ready;
    Vertex_t out_point;
    logic    out_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    inverse_transform_unit #(
        .FRAC_BITS (8),
        .ACC_W     (34)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_point  (in_point),
        .in_matrix (in_matrix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_point (out_point),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic Vertex_t vtx(input logic [15:0] x, input logic [15:0] y,
                                    input logic [15:0] z);
        vtx = {x, y, z};
    endfunction

    function automatic Vector_t vec(input logic [15:0] i, input logic [15:0] j,
                                    input logic [15:0] k);
        vec = {i, j, k};
    endfunction

    function automatic Matrix_t mtx(input Vector_t v1, input Vector_t v2, input Vector_t v3);
        mtx = {v1, v2, v3};
    endfunction

    // Present one input, accept it, and count cycles until out_valid (bounded)
    task automatic send(input Vertex_t p, input Matrix_t m, output int lat);
        @(negedge clk);
        in_point  = p;
        in_matrix = m;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Complete the output handshake
    task automatic recv();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    int      lat;
    Vertex_t held;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_point  = '0;
        in_matrix = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 48'(in_ready), 48'd1);
        check("rst_out_valid", 48'(out_valid), 48'd0);
        check("rst_out_point", out_point, 48'h0);
        check("rst_out_ovf", 48'(out_ovf), 48'd0);
        rst_n = 1'b1;

        // Diagonal matrix
        send(vtx(16'h00c0, 16'h0a80, 16'hfee0),
             mtx(vec(16'h0020, 16'h0, 16'h0), vec(16'h0, 16'h00e0, 16'h0),
                 vec(16'h0, 16'h0, 16'h0080)), lat);
        check("diag_latency", 48'(lat), 48'd9);
        check("diag_point", out_point, 48'h0018_0930_ff70);
        check("diag_ovf", 48'(out_ovf), 48'd0);
        check("diag_in_ready", 48'(in_ready), 48'd0);
        recv();
        check("diag_idle", 48'(in_ready), 48'd1);

        // Transpose check
        send(vtx(16'h0100, 16'h0200, 16'h0300),
             mtx(vec(16'h0, 16'h0100, 16'h0), vec(16'h0, 16'h0, 16'h0100),
                 vec(16'h0100, 16'h0, 16'h0)), lat);
        check("tp_latency", 48'(lat), 48'd9);
        check("tp_point", out_point, 48'h0200_0300_0100);
        recv();

        // Truncation toward minus infinity
        send(vtx(16'hffff, 16'h0, 16'h0),
             mtx(vec(16'h0080, 16'h0, 16'h0), vec(16'h0, 16'h0, 16'h0),
                 vec(16'h0, 16'h0, 16'h0)), lat);
        check("trunc_point", out_point, 48'hffff_0000_0000);
        recv();

        // Overflow
        send(vtx(16'h7f00, 16'h7f00, 16'h0),
             mtx(vec(16'h0200, 16'h0200, 16'h0), vec(16'h0, 16'h0, 16'h0),
                 vec(16'h0, 16'h0, 16'h0)), lat);
`ifdef Q8_8_SAT_EN
        check("ovf_x", 48'(out_point.x), 48'h7fff);
        check("ovf_flag", 48'(out_ovf), 48'd1);
`else
        check("ovf_x", 48'(out_point.x), 48'hfc00);
        check("ovf_flag", 48'(out_ovf), 48'd0);
`endif
        recv();

        // Backpressure: result held while new data waits
        send(vtx(16'h0100, 16'h0200, 16'h0300),
             mtx(vec(16'h0100, 16'h0, 16'h0), vec(16'h0, 16'h0100, 16'h0),
                 vec(16'h0, 16'h0, 16'h0100)), lat);
        held = out_point;
        check("bp_first", held, 48'h0100_0200_0300);
        @(negedge clk);
        in_point  = vtx(16'h0040, 16'h0, 16'h0);
        in_matrix = mtx(vec(16'h0200, 16'h0, 16'h0), vec(16'h0, 16'h0, 16'h0),
                        vec(16'h0, 16'h0, 16'h0));
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_point", out_point, held);
            check("bp_hold_valid", 48'(out_valid), 48'd1);
            check("bp_in_ready", 48'(in_ready), 48'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_released_idle", 48'(in_ready), 48'd1);
        check("bp_released_valid", 48'(out_valid), 48'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_new_accepted", 48'(in_ready), 48'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_new_latency", 48'(lat), 48'd9);
        check("bp_new_point", out_point, 48'h0080_0000_0000);
        recv();

        // Reset during CALC cycle 4
        @(negedge clk);
        in_point  = vtx(16'h0100, 16'h0100, 16'h0100);
        in_matrix = mtx(vec(16'h0100, 16'h0100, 16'h0100), vec(16'h0, 16'h0, 16'h0),
                        vec(16'h0, 16'h0, 16'h0));
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 48'(out_valid), 48'd0);
        check("mid_rst_point", out_point, 48'h0);
        check("mid_rst_in_ready", 48'(in_ready), 48'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 48'(in_ready), 48'd1);
        check("post_rst_valid", 48'(out_valid), 48'd0);
        send(vtx(16'h0100, 16'hff00, 16'h0080),
             mtx(vec(16'h0100, 16'h0100, 16'h0100), vec(16'h0200, 16'h0, 16'h0),
                 vec(16'h0, 16'h0, 16'hff00)), lat);
        check("post_rst_latency", 48'(lat), 48'd9);
        check("post_rst_point", out_point, 48'h0080_0200_ff80);
        recv();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inverse_transform_unit.md
# inverse_transform_unit

Multi-cycle inverse of the vertex transform: it computes Result = Mᵀ · Point in signed Q8.8, applying the transpose of a 3×3 column-matrix. For orthonormal (rotation) matrices this undoes the forward transform. The unit sits between the ray-generation stage and the intersection stage, mapping world-space points into object space. It reuses a single Q8.8 multiply-accumulate over nine cycles and has valid/ready handshakes on both sides.

## Interface
Parameters:
- FRAC_BITS, 8: fractional bits of the Q format; only 8 is supported.
- ACC_W, 34: accumulator width in bits; holds three Q16.16 products plus sign/guard.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_point/in_matrix valid
- in_ready  out  1  unit can accept (IDLE)
- in_point  in  Vertex_t  x, y, z in Q8.8
- in_matrix  in  Matrix_t  columns v1, v2, v3, each Vector_t {i, j, k}
- out_valid  out  1  out_point valid
- out_ready  in  1  downstream accepts
- out_point  out  Vertex_t  transformed point in Q8.8
- out_ovf  out  1  at least one component saturated (see Configuration)

## Operation
- Component mapping:
  - out.x = v1.i·x + v1.j·y + v1.k·z
  - out.y = dot(v2, P)
  - out.z = dot(v3, P)
- FSM states:
  - IDLE: in_ready=1. On in_valid, register point and matrix, clear the accumulator, set row=0 and term=0, go to CALC.
  - CALC: one MAC per cycle; term counts 0..2 and row counts 0..2.
    - When term==2, write the rounded accumulator to component[row], clear the accumulator, and increment row.
    - After row 2 / term 2, go to OUT.
  - OUT: out_valid=1. On out_ready, go to IDLE.
- Arithmetic:
  - Each product is a full signed 16×16→32 (Q16.16), sign-extended to ACC_W and summed.
  - Result = accumulator >>> 8 (arithmetic shift; truncation toward −∞), reduced to 16 bits per Configuration.
- Input fields are sampled only at the accept edge. Input changes afterwards are ignored.
- in_valid during CALC or OUT is not accepted (in_ready=0).

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_point=0, out_ovf=0, accumulator and counters 0.
- Latency: accept on edge E0 → CALC on edges E1..E9 → out_valid high after E9.
- Minimum initiation interval is 11 cycles: the output handshake at E10 returns the unit to IDLE, and the next accept is at E11.
- out_point and out_ovf are stable for the whole time out_valid=1. They change only on an accept/compute, never while stalled.
- out_valid stays high through any amount of out_ready backpressure.
- Reset asserted mid-CALC or mid-OUT: the in-flight result is discarded immediately (asynchronous) and all outputs return to reset values.
- out_ready high while out_valid=0 has no effect.

## Configuration
- Q8_8_SAT_EN defined:
  - A result outside [−32768, 32767] LSB clamps to 16'h8000 or 16'h7FFF.
  - out_ovf is the OR of per-component saturation for the current result.
- Q8_8_SAT_EN undefined:
  - The low 16 bits are kept (two's-complement wrap).
  - out_ovf is tied to 0.

## Structure
- The shared Primitives package already provides Vertex_t, Vector_t and Matrix_t.
- Add to that package: Q_FRAC=8, Q_MAX=16'h7FFF, Q_MIN=16'h8000.
- The FSM state enum stays local to the unit.
- One sub-module, q8_8_mac: signed multiply, accumulate into ACC_W, and a rounding/reduce output with a saturate flag (macro-controlled). The unit instantiates it once.

## Test plan
- Diagonal matrix: P=(00c0, 0a80, fee0), v1=(0020,0,0), v2=(0,00e0,0), v3=(0,0,0080) → out=(0018, 0930, ff70), out_ovf=0; out_valid rises exactly 9 cycles after accept.
- Transpose check: v1=(0,0100,0), v2=(0,0,0100), v3=(0100,0,0), P=(0100,0200,0300) → out=(0200,0300,0100). A forward (non-transposed) transform would give (0300,0100,0200).
- Truncation: P=(ffff,0,0), v1=(0080,0,0), v2=v3=0 → out.x=ffff (floor of −0.5 LSB).
- Overflow: P=(7f00,7f00,0), v1=(0200,0200,0) → with Q8_8_SAT_EN: out.x=7fff, out_ovf=1. Without it: out.x=fc00, out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new data → out_point unchanged, in_ready=0, the new data is not taken. Release → one handshake, IDLE, then the new data is accepted.
- Reset mid-operation: pull rst_n low during CALC cycle 4 → out_valid=0, out_point=0 and in_ready=1 after release. The next transaction yields the correct result.
